// File: rtl/ni_packetizer_if.sv
// Bundle between the NI packetizer and its environment: message descriptors,
// the data word stream and the flit write port into the router's local FIFO.
`ifndef AXIS
`define AXIS 4
`endif
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

interface ni_packetizer_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshakes: a descriptor or data word transfers on the posedge where its
  // valid and ready are both high; valid may not depend on ready. flit_wr is a
  // plain strobe: a flit is written on every posedge with flit_wr high, and
  // the packetizer only raises it when fifo_full is low.
  logic                  msg_valid;
  logic                  msg_ready;
  logic [`AXIS-1:0]      msg_dst;
  logic [7:0]            msg_len;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  flit_wr;
  logic [DATA_WIDTH+2:0] flit_out;

  modport master (
    output msg_valid, msg_dst, msg_len, data_valid, data_in, fifo_full,
    input  msg_ready, data_ready, flit_wr, flit_out
  );

  modport slave (
    input  msg_valid, msg_dst, msg_len, data_valid, data_in, fifo_full,
    output msg_ready, data_ready, flit_wr, flit_out
  );
endinterface

// File: rtl/ni_packetizer.sv
// NI transmit side: turns a (dst, len) descriptor plus len data words into a
// HEADER, len flits (last one TAIL) or HEADER+empty TAIL for len==0.
`ifndef AXIS
`define AXIS 4
`endif
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module ni_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [`AXIS-1:0]     cur_addr_rst,
  ni_packetizer_if.slave       bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pkt_sent,
  output logic [1:0]           dbg_state
);
  localparam int HDR_W = 2 * `AXIS + 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAD  = 2'd1,
    BODY  = 2'd2,
    ZTAIL = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [`AXIS-1:0]      cur_addr;
  logic [`AXIS-1:0]      dst_q, dst_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;
  logic [DATA_WIDTH-1:0] hdr_body;
  logic                  wr;

  // The node address is strapped in through reset and held for the whole run.
  always_ff @(posedge clk) begin
    if (rst) cur_addr <= cur_addr_rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    hdr_body             = '0;
    hdr_body[HDR_W-1:0]  = {len_q, cur_addr, dst_q};
  end

  always_comb begin
    state_d        = state_q;
    dst_d          = dst_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    sent_d         = sent_q;
    wr             = 1'b0;
    bus.msg_ready  = 1'b0;
    bus.data_ready = 1'b0;
    bus.flit_out   = '0;
    case (state_q)
      IDLE: begin
        bus.msg_ready = 1'b1;
        if (bus.msg_valid) begin
          dst_d   = bus.msg_dst;
          len_d   = bus.msg_len;
          cnt_d   = bus.msg_len;
          state_d = HEAD;
        end
      end
      HEAD: begin
        wr           = ~bus.fifo_full;
        bus.flit_out = {`HEADER, hdr_body};
        if (wr) state_d = (len_q == 8'd0) ? ZTAIL : BODY;
      end
      BODY: begin
        // Data is only taken on a cycle where its flit is written too.
        bus.data_ready = ~bus.fifo_full;
        wr             = bus.data_valid & ~bus.fifo_full;
        bus.flit_out   = {((cnt_q == 8'd1) ? `TAIL : `PAYLOAD), bus.data_in};
        if (wr) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = IDLE;
            sent_d  = sent_q + 1'b1;
          end
        end
      end
      ZTAIL: begin
        wr           = ~bus.fifo_full;
        bus.flit_out = {`TAIL, {DATA_WIDTH{1'b0}}};
        if (wr) begin
          state_d = IDLE;
          sent_d  = sent_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.flit_wr = wr;
  assign busy        = (state_q != IDLE);
  assign pkt_sent    = sent_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: packet-level model of expected flits, per-cycle
// compare process, and directed scenarios with hand-computed literals.
module tb_ni_packetizer;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int AW = `AXIS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cur_addr_rst;
  logic          busy;
  logic [CW-1:0] pkt_sent;
  logic [1:0]    dbg_state;

  ni_packetizer_if #(.DATA_WIDTH(DW)) bus();

  ni_packetizer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cur_addr_rst(cur_addr_rst), .bus(bus),
    .busy(busy), .pkt_sent(pkt_sent), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int acc_cyc = 0;
  logic [DW+2:0] exp_q[$];
  logic [DW+2:0] wr_log[$];
  int            wr_cyc[$];
  logic [DW-1:0] data_q[$];
  logic [CW-1:0] exp_sent = '0;
  logic          exp_busy = 1'b0;
  logic          dr_seen = 1'b0;
  logic          accept_m;
  logic          fire;
  logic [DW+2:0] exp_f;
  logic [AW-1:0] src_model;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW+2:0] hdr(input logic [AW-1:0] dst, input logic [AW-1:0] src,
                                        input logic [7:0] len);
    logic [DW-1:0] b;
    b = '0;
    b[2*AW+7:0] = {len, src, dst};
    return {`HEADER, b};
  endfunction

  function automatic logic [DW+2:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 'x;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < wr_cyc.size()) return wr_cyc[i];
    return -1000;
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_sent = '0;
      exp_busy = 1'b0;
    end else begin
      accept_m = bus.msg_valid && !exp_busy;
      chk("pkt_sent", pkt_sent, exp_sent);
      chk("busy", busy, exp_busy);
      chk("msg_ready", bus.msg_ready, !exp_busy);
      if (bus.data_ready) dr_seen = 1'b1;
      if (bus.fifo_full) chk("stall", {bus.flit_wr, bus.data_ready}, 2'b00);
      if (bus.data_valid && bus.data_ready) chk("consume_has_flit", bus.flit_wr, 1'b1);
      if (bus.flit_wr) begin
        wr_log.push_back(bus.flit_out);
        wr_cyc.push_back(cyc);
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL flit: got unexpected write %0h, expected none", bus.flit_out);
        end else begin
          exp_f = exp_q.pop_front();
          chk("flit", bus.flit_out, exp_f);
          if (exp_f[DW+2:DW] == `TAIL) begin
            exp_sent = exp_sent + 1'b1;
            exp_busy = 1'b0;
          end
        end
      end
      if (accept_m) exp_busy = 1'b1;
    end
  end

  // ---------------- data feeder ----------------
  initial begin
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    forever begin
      @(negedge clk);
      fire = bus.data_valid && bus.data_ready && !rst;
      @(posedge clk);
      #2;
      if (fire && data_q.size() > 0) void'(data_q.pop_front());
      bus.data_valid = (data_q.size() > 0);
      bus.data_in    = (data_q.size() > 0) ? data_q[0] : '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [AW-1:0] addr);
    rst          = 1'b1;
    cur_addr_rst = addr;
    src_model    = addr;
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_q.delete();
  endtask

  task automatic send_msg(input logic [AW-1:0] dst, input logic [7:0] len, input logic [DW-1:0] base);
    logic          acc;
    int            n;
    logic [DW-1:0] w;
    exp_q.push_back(hdr(dst, src_model, len));
    if (len == 8'd0) exp_q.push_back({`TAIL, {DW{1'b0}}});
    for (int i = 0; i < int'(len); i++) begin
      w = base + DW'(i);
      data_q.push_back(w);
      exp_q.push_back({((i == int'(len) - 1) ? `TAIL : `PAYLOAD), w});
    end
    bus.msg_valid = 1'b1;
    bus.msg_dst   = dst;
    bus.msg_len   = len;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.msg_ready && !rst;
      if (acc) acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    bus.msg_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept: descriptor not taken within %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    #1;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d flits still pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_cnt < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (wr_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_wr: %0d writes seen, expected %0d", wr_cnt, target);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int b;
    bus.msg_valid = 1'b0;
    bus.msg_dst   = '0;
    bus.msg_len   = '0;
    bus.fifo_full = 1'b0;
    cur_addr_rst  = 4'b0001;
    src_model     = 4'b0001;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_msg_ready", bus.msg_ready, 1'b1);
    chk("rst_data_ready", bus.data_ready, 1'b0);
    chk("rst_flit_wr", bus.flit_wr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_sent", pkt_sent, 4'd0);
    chk("rst_state", dbg_state, 2'd0);
    @(posedge clk);
    #1;

    // 1: basic len=3 packet
    b = wr_log.size();
    send_msg(4'b0110, 8'd3, 32'hA);
    wait_idle();
    chk("t1_header", log_at(b), {`HEADER, 32'h0000_0316});
    chk("t1_pay0", log_at(b + 1), {`PAYLOAD, 32'hA});
    chk("t1_pay1", log_at(b + 2), {`PAYLOAD, 32'hB});
    chk("t1_tail", log_at(b + 3), {`TAIL, 32'hC});
    chk("t1_hdr_latency", cyc_at(b) - acc_cyc, 1);
    chk("t1_back2back", cyc_at(b + 3) - cyc_at(b), 3);
    chk("t1_pkt_sent", pkt_sent, 4'd1);
    chk("t1_busy", busy, 1'b0);

    // 2: len=0 packet
    dr_seen = 1'b0;
    b = wr_log.size();
    send_msg(4'b0010, 8'd0, 32'h0);
    wait_idle();
    chk("t2_header", log_at(b), {`HEADER, 32'h0000_0012});
    chk("t2_tail", log_at(b + 1), {`TAIL, 32'h0});
    chk("t2_gap", cyc_at(b + 1) - cyc_at(b), 1);
    chk("t2_no_data_ready", dr_seen, 1'b0);
    chk("t2_pkt_sent", pkt_sent, 4'd2);

    // 3: len=4, fifo full for 3 cycles after the 2nd payload
    b = wr_log.size();
    send_msg(4'b0011, 8'd4, 32'h100);
    wait_wr(b + 3);
    bus.fifo_full = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_stalled_count", wr_cnt - b, 3);
    bus.fifo_full = 1'b0;
    @(negedge clk);
    #1;
    chk("t3_resume", bus.flit_wr, 1'b1);
    wait_idle();
    chk("t3_total", wr_cnt - b, 5);
    chk("t3_pay2", log_at(b + 3), {`PAYLOAD, 32'h102});
    chk("t3_tail", log_at(b + 4), {`TAIL, 32'h103});
    chk("t3_pkt_sent", pkt_sent, 4'd3);

    // 4: back-to-back len=1 descriptors
    b = wr_log.size();
    send_msg(4'b0101, 8'd1, 32'h200);
    send_msg(4'b0110, 8'd1, 32'h300);
    wait_idle();
    chk("t4_h1_t1", cyc_at(b + 1) - cyc_at(b), 1);
    chk("t4_h1_h2", cyc_at(b + 2) - cyc_at(b), 3);
    chk("t4_h1_t2", cyc_at(b + 3) - cyc_at(b), 4);
    chk("t4_tail2", log_at(b + 3), {`TAIL, 32'h300});
    chk("t4_pkt_sent", pkt_sent, 4'd5);

    // 5: reset after 1st payload of a len=5 packet, then a fresh packet
    b = wr_log.size();
    send_msg(4'b1010, 8'd5, 32'h400);
    wait_wr(b + 2);
    do_reset(4'b1001);
    @(negedge clk);
    #1;
    chk("t5_msg_ready", bus.msg_ready, 1'b1);
    chk("t5_data_ready", bus.data_ready, 1'b0);
    chk("t5_flit_wr", bus.flit_wr, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_pkt_sent", pkt_sent, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_more_flits", wr_cnt - b, 2);
    b = wr_log.size();
    send_msg(4'b0110, 8'd2, 32'h500);
    wait_idle();
    chk("t5_new_header", log_at(b), {`HEADER, 32'h0000_0296});
    chk("t5_new_tail", log_at(b + 2), {`TAIL, 32'h501});
    chk("t5_new_pkt_sent", pkt_sent, 4'd1);

    // 6: counter wrap with 16 len=1 packets, some addressed to self
    do_reset(4'b1001);
    for (int i = 0; i < 16; i++) begin
      send_msg(((i % 2) == 1) ? 4'b1001 : 4'b0001, 8'd1, 32'h600 + 32'(i));
      wait_idle();
      if (i == 14) chk("t6_pkt_15", pkt_sent, 4'd15);
    end
    chk("t6_wrap", pkt_sent, 4'd0);
    chk("t6_self_hdr", log_at(wr_log.size() - 2), {`HEADER, 32'h0000_0199});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
